// File: rtl/addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : addsub_pipe                                                      |
// | Brief   : segmented, pipelined add/sub with carry-in, C/V/Z/N flags and    |
// |           valid/ready; optional clamp on overflow via ADDSUB_SATURATE_EN   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int               c_stages   = WIDTH / SEG;
  localparam int               c_last     = c_stages - 1;
  localparam logic [WIDTH-1:0] c_seg_mask = WIDTH'({SEG{1'b1}});
`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] c_max_pos  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_max_neg  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Per-stage registers; r_a/r_b hold the not-yet-consumed segments shifted
  // down so the next stage always finds its segment in the low SEG bits.
  logic             r_v [c_stages];
  logic [WIDTH-1:0] r_a [c_stages];
  logic [WIDTH-1:0] r_b [c_stages];
  logic [WIDTH-1:0] r_y [c_stages];
  logic             r_c [c_stages];
  logic             r_vf;
  logic             r_z;
  logic             r_n;

  logic             w_vin   [c_stages];
  logic [WIDTH-1:0] w_ain   [c_stages];
  logic [WIDTH-1:0] w_bin   [c_stages];
  logic [WIDTH-1:0] w_yin   [c_stages];
  logic [WIDTH-1:0] w_ynext [c_stages];
  logic             w_cin   [c_stages];
  logic             w_cout  [c_stages];
  logic [SEG-1:0]   w_sum   [c_stages];

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin0;
  logic [WIDTH-1:0] w_y_raw;
  logic [WIDTH-1:0] w_y_fin;
  logic             w_ovf;

  assign w_adv    = !r_v[c_last] || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = op[0] ? ~b : b;
  assign w_cin0   = op[1] ? ci : op[0];

  for (genvar k = 0; k < c_stages; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_vin[k] = in_valid;
      assign w_ain[k] = a;
      assign w_bin[k] = w_b_eff;
      assign w_cin[k] = w_cin0;
      assign w_yin[k] = '0;
    end else begin : g_next
      assign w_vin[k] = r_v[k-1];
      assign w_ain[k] = r_a[k-1];
      assign w_bin[k] = r_b[k-1];
      assign w_cin[k] = r_c[k-1];
      assign w_yin[k] = r_y[k-1];
    end
    assign {w_cout[k], w_sum[k]} = {1'b0, w_ain[k][SEG-1:0]} + {1'b0, w_bin[k][SEG-1:0]}
                                 + (SEG+1)'(w_cin[k]);
    assign w_ynext[k] = (w_yin[k] & ~(c_seg_mask << (k*SEG))) | (WIDTH'(w_sum[k]) << (k*SEG));
  end

  // Carry into the MSB is recovered as a^b'^sum at that bit.
  assign w_y_raw = w_ynext[c_last];
  assign w_ovf   = w_ain[c_last][SEG-1] ^ w_bin[c_last][SEG-1] ^ w_sum[c_last][SEG-1]
                 ^ w_cout[c_last];

`ifdef ADDSUB_SATURATE_EN
  assign w_y_fin = !w_ovf ? w_y_raw : (w_y_raw[WIDTH-1] ? c_max_pos : c_max_neg);
`else
  assign w_y_fin = w_y_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < c_stages; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_y[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_vf <= 1'b0;
      r_z  <= 1'b0;
      r_n  <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < c_stages; k++) begin
        r_v[k] <= w_vin[k];
        r_a[k] <= w_ain[k] >> SEG;
        r_b[k] <= w_bin[k] >> SEG;
        r_y[k] <= w_ynext[k];
        r_c[k] <= w_cout[k];
      end
      r_y[c_last] <= w_y_fin;
      r_vf        <= w_ovf;
      r_z         <= (w_y_fin == '0);
      r_n         <= w_y_fin[WIDTH-1];
    end
  end

  assign out_valid = r_v[c_last];
  assign y         = r_y[c_last];
  assign c         = r_c[c_last];
  assign v         = r_vf;
  assign z         = r_z;
  assign n         = r_n;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_addsub_pipe                                                   |
// | Brief   : directed vector table plus stall and reset sequences             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_addsub_pipe;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] y;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  op = '0;
  logic        ci = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y;
  logic        c, v, z, n;

  int total = 0;
  int bad   = 0;

  vec_t        vecs [12];
  logic [15:0] s5_a [4];
  logic [15:0] s5_y [4];

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(16), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .c(c), .v(v), .z(z), .n(n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int sent, got, stall;
    bit seen;

    //          op     a         b         ci    y         c     v     z     n
    vecs[0]  = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2'b01, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'b00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{2'b10, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 16'h0100, 16'h0000, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SATURATE_EN
    vecs[0].y = 16'h7FFF; vecs[0].n = 1'b0;
    vecs[4].y = 16'h8000; vecs[4].n = 1'b1; vecs[4].z = 1'b0;
    vecs[8].y = 16'h8000; vecs[8].n = 1'b1;
`endif
    s5_a = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    s5_y = '{16'h1011, 16'h2011, 16'h3011, 16'h4011};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'h0);
    check("rst_flags", 32'({c, v, z, n}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; ci = vecs[i].ci;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_lat1", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_lat2", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("v%0d_c", i), 32'(c), 32'(vecs[i].c));
      check($sformatf("v%0d_v", i), 32'(v), 32'(vecs[i].v));
      check($sformatf("v%0d_z", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("v%0d_n", i), 32'(n), 32'(vecs[i].n));
    end

    // Four back-to-back ops; the first result is refused for three cycles.
    @(negedge clk);
    sent = 0; got = 0; stall = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      out_ready = (stall == 0);
      if (sent < 4) begin
        in_valid = 1'b1; op = 2'b00; a = s5_a[sent]; b = 16'h0011; ci = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall > 0) begin
        check("s5_stall_in_ready", 32'(in_ready), 32'd0);
        check("s5_stall_valid", 32'(out_valid), 32'd1);
        check("s5_stall_y", 32'(y), 32'(s5_y[got]));
        stall--;
      end else if (out_valid) begin
        check($sformatf("s5_y%0d", got), 32'(y), 32'(s5_y[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("s5_delivered", 32'(got), 32'd4);
    check("s5_accepted", 32'(sent), 32'd4);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("s5_no_dup", 32'(out_valid), 32'd0);
    end

    // Reset with two ops in flight and a third presented alongside rst.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a = 16'h0101; b = 16'h0101; ci = 1'b0;
    @(negedge clk);
    a = 16'h0202;
    @(negedge clk);
    rst = 1'b1;
    a = 16'h0303;
    @(posedge clk);
    #1;
    check("s6_out_valid", 32'(out_valid), 32'd0);
    check("s6_y", 32'(y), 32'h0);
    check("s6_flags", 32'({c, v, z, n}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("s6_in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("s6_no_stale", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
